// File: rtl/cpu_player_gen.sv
// cpu_player_gen: LFSR-driven computer opponent that presses when threshold exceeds the random value
module cpu_player_gen #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'b1001000000,
  parameter logic [WIDTH-1:0] SEED  = 10'd1,
  parameter int               HOLD  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] threshold,
  output logic             press,
  output logic [WIDTH-1:0] rand_out,
  output logic             armed
);
  localparam int CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF} state_t;
  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] lfsr, lfsr_n, stepped, reseed;
  logic             press_n;
  assign stepped  = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  assign reseed   = (seed == '0) ? SEED : seed;
  assign rand_out = lfsr;
  assign armed    = state == ARMED;
  // next-state: disable beats load, load beats tick; compare uses the pre-step value
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lfsr_n  = lfsr;
    press_n = 1'b0;
    if (load) lfsr_n = reseed;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (load) begin
      state_n = ARMED;
      cnt_n   = '0;
    end else if (state == IDLE) begin
      state_n = ARMED;
    end else if (tick) begin
      lfsr_n = stepped;
      if (state == HOLDOFF) begin
        cnt_n   = cnt - CW'(1);
        state_n = (cnt == CW'(1)) ? ARMED : HOLDOFF;
      end else if (threshold > lfsr) begin
        press_n = 1'b1;
        state_n = (HOLD == 0) ? ARMED : HOLDOFF;
        cnt_n   = CW'(HOLD);
      end
    end
  end
  // state, holdoff count, LFSR and press pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      lfsr  <= SEED;
      press <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lfsr  <= lfsr_n;
      press <= press_n;
    end
  end
endmodule

// File: tb/tb_cpu_player_gen.sv
// tb_cpu_player_gen: directed plus random checks of cpu_player_gen against a behavioural model
module tb_cpu_player_gen;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1, tick = 1'b0, load = 1'b0;
  logic [9:0] seed = '0, threshold = '0;
  logic       press, armed;
  logic [9:0] rand_out;
  int         passed = 0, total = 0;
  logic [9:0] m_l;
  int         m_mode, m_cnt;
  logic       m_p;
  cpu_player_gen dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tick(tick), .load(load),
    .seed(seed), .threshold(threshold), .press(press), .rand_out(rand_out), .armed(armed)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] step(input logic [9:0] v);
    logic fb;
    fb = ($countones(v & 10'h240) % 2) == 1;
    return {v[8:0], fb};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic model_reset();
    m_l = 10'd1; m_mode = 0; m_cnt = 0; m_p = 1'b0;
  endtask
  task automatic cyc(input logic e, input logic t, input logic l, input logic [9:0] s,
                     input logic [9:0] th, input string tag);
    enable = e; tick = t; load = l; seed = s; threshold = th;
    @(posedge clk);
    m_p = 1'b0;
    if (l) m_l = (s == 0) ? 10'd1 : s;
    if (!e) begin
      m_mode = 0; m_cnt = 0;
    end else if (l) begin
      m_mode = 1; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (t) begin
      if (m_mode == 1) begin
        if (th > m_l) begin m_p = 1'b1; m_mode = 2; m_cnt = 2; end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_mode = 1;
      end
      m_l = step(m_l);
    end
    #1;
    chk({tag, ".press"}, press, m_p);
    chk({tag, ".rand"}, rand_out, m_l);
    chk({tag, ".armed"}, armed, m_mode == 1);
  endtask
  initial begin
    int seq_exp [8] = '{2, 4, 8, 16, 32, 64, 129, 258};
    logic prev_t, prev_p;
    for (int i = 0; i < 4; i++) begin
      tick = i[0];
      @(posedge clk);
      #1;
      chk("reset.press", press, 0);
      chk("reset.rand", rand_out, 1);
      chk("reset.armed", armed, 0);
    end
    reset_n = 1'b1;
    model_reset();
    cyc(1, 1, 0, 0, 10'd1023, "enable_rise");
    chk("enable_rise.armed1", armed, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, 0, 0, "seq");
      chk("seq.table", rand_out, seq_exp[i]);
    end
    cyc(1, 0, 1, 10'd1, 10'd2, "hold.load");
    cyc(1, 1, 0, 0, 10'd2, "hold.t1");
    chk("hold.first_press", press, 1);
    cyc(1, 0, 0, 0, 10'd2, "hold.gap");
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 10'd1023, "hold.tick");
      cyc(1, 0, 0, 0, 10'd1023, "hold.gap");
    end
    cyc(1, 0, 1, 10'd5, 10'd5, "eq.load");
    cyc(1, 1, 0, 0, 10'd5, "eq.tick");
    chk("eq.nopress", press, 0);
    cyc(1, 0, 1, 10'd5, 10'd6, "gt.load");
    cyc(1, 1, 0, 0, 10'd6, "gt.tick");
    chk("gt.press", press, 1);
    chk("gt.rand10", rand_out, 10);
    cyc(1, 1, 1, 10'd0, 10'd1023, "prio.loadtick");
    chk("prio.rand1", rand_out, 1);
    cyc(1, 0, 1, 10'd0, 10'd0, "prio.load0");
    cyc(1, 1, 0, 0, 10'd2, "drop.press");
    cyc(0, 0, 0, 0, 10'd1023, "drop.off");
    cyc(0, 1, 0, 0, 10'd1023, "drop.idle_tick");
    chk("drop.frozen", rand_out, 2);
    cyc(1, 1, 0, 0, 10'd1023, "drop.rearm");
    cyc(1, 1, 0, 0, 10'd1023, "drop.repress");
    chk("drop.repress_now", press, 1);
    cyc(1, 0, 0, 0, 10'd1023, "drop.gap");
    prev_t = 1'b0;
    prev_p = press;
    for (int i = 0; i < 400; i++) begin
      logic e, t, l;
      logic [9:0] s;
      e = $urandom_range(14) != 0;
      t = !prev_t && ($urandom_range(2) == 0);
      l = $urandom_range(19) == 0;
      s = ($urandom_range(3) == 0) ? 10'd0 : 10'($urandom);
      cyc(e, t, l, s, 10'($urandom), "rand");
      chk("rand.no_consec", prev_p & press, 0);
      prev_t = t;
      prev_p = press;
    end
    cyc(1, 0, 1, 10'd1, 10'd1023, "async.load");
    cyc(1, 1, 0, 0, 10'd1023, "async.press");
    #2 reset_n = 1'b0;
    #1;
    chk("async.press_drop", press, 0);
    chk("async.rand", rand_out, 1);
    chk("async.armed", armed, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1, 0, 0, 0, 0, "async.rearm");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cpu_player_gen.md
# cpu_player_gen

Pseudo-random opponent generator for the two-player reaction game: steps a WIDTH-bit maximal-length LFSR once per game tick and raises a single-cycle `press` whenever the operator threshold is strictly greater than the current random value. It is the producer side of the unsigned threshold comparison used in the game datapath: it sources the random operand, performs the compare on tick, and emits a debounced press event into the player-input path. A post-press holdoff limits how often the computer player can press.

## Interface
- WIDTH, 10, bit width of LFSR, threshold and random output
- TAPS, 10'b1001000000, feedback mask; feedback bit = XOR-reduce(lfsr & TAPS), default is x^10+x^7+1
- SEED, 10'd1, reset/load-fallback value; must be nonzero
- HOLD, 2, number of ticks ignored after a press (0 = no holdoff)
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  game running; 0 freezes LFSR and suppresses presses
- tick  input  1  one-cycle game-rate strobe
- load  input  1  one-cycle reseed request
- seed  input  WIDTH  reseed value, sampled when load=1
- threshold  input  WIDTH  unsigned difficulty setting (switches)
- press  output  1  registered one-cycle press pulse
- rand_out  output  WIDTH  current LFSR value (registered)
- armed  output  1  high in ARMED state

## Operation
- Reset (async, reset_n=0): lfsr=SEED, press=0, state=IDLE, holdoff count=0, armed=0.
- LFSR: shift left; next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}. All-zero state never reachable; seed=0 on load replaced by SEED.
- States: IDLE, ARMED, HOLDOFF.
  - IDLE: enable=1 -> ARMED next edge. Ticks ignored, LFSR frozen.
  - ARMED, tick=1: compare threshold > lfsr (unsigned, strict, pre-step value); if true press<=1 and state<=HOLDOFF with count=HOLD (stays ARMED if HOLD=0); LFSR steps regardless.
  - HOLDOFF, tick=1: LFSR steps, no compare; count decrements; count==1 on the tick -> ARMED.
  - Any state, enable=0: -> IDLE, count=0, press=0 next edge.
- press is high for exactly one cycle per qualifying tick; never high two consecutive cycles (tick is a one-cycle strobe).
- load=1 (enable any): lfsr<=seed (or SEED if seed==0); if enabled, state<=ARMED and count cleared; press<=0.
- Simultaneous load and tick: load wins; no step, no compare, no press.
- Equality: threshold==lfsr -> no press. threshold=0 -> never presses. Max threshold still fails vs lfsr=all-ones.

## Timing
- press asserted in the cycle following the tick edge that qualified; latency 1 clock.
- rand_out updates on the tick edge; reflects the post-step value in the same cycle press is high.
- enable rise -> armed=1 one cycle later; tick in that same enable-rise cycle ignored.
- reset_n deassertion mid-game: outputs stay at reset values until enable observed on a following edge.
- Reset asserted while press=1: press drops immediately (async).

## Test plan
- Reset: reset_n=0 with enable=1, tick toggling -> press=0, rand_out=1, armed=0; release, enable=1 -> armed=1 after one edge.
- Sequence: seed 1, threshold=0, 8 ticks -> rand_out 2,4,8,16,32,64,129,258; press never asserted.
- Press/holdoff: rand_out=1, threshold=2, HOLD=2, ticks -> press 1 cycle after first tick (rand_out=2); next two ticks no press though 4>... irrelevant; third tick compares 8 vs 2, no press; armed restored after second holdoff tick.
- Equality/strict: load seed=10'd5, threshold=5, tick -> no press; load seed=5, threshold=6, tick -> press, rand_out=10.
- Load priority: load=1 seed=0 with tick=1 same cycle -> rand_out=SEED(1), no step, press=0; load seed=0 alone -> rand_out=1.
- Enable drop: in HOLDOFF with count=2, enable=0 for one cycle then 1 -> state IDLE then ARMED, ticks during IDLE leave rand_out unchanged; next qualifying tick presses without waiting out old holdoff.
